jkff: RTL and testbench

Edge-triggered JK flip-flop bank with complementary outputs, used as a basic storage and toggle element in sequential logic. Each bit samples its J/K pair on the rising clock edge and holds, sets, resets or toggles. An asynchronous active-low reset forces a known state. The default configuration is a single bit (WIDTH = 1).

---
 rtl/jkff_pkg.sv | 30 +++
 rtl/jkff_jk_bit.sv | 22 ++
 rtl/jkff.sv | 31 +++
 tb/tb_jkff.sv | 139 +++++++++++++
 4 files changed

// File: rtl/jkff_pkg.sv
// JK flip-flop encodings and the per-bit next-state function shared by the bank.
package jkff_pkg;

    localparam int unsigned JK_OP_W = 2;

    // {j, k} concatenation mapped onto the four JK behaviours.
    typedef enum logic [JK_OP_W-1:0] {
        JK_HOLD   = 2'b00,
        JK_CLEAR  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

    function automatic jk_op_e jk_decode(input logic j, input logic k);
        return jk_op_e'({j, k});
    endfunction

    function automatic logic jk_next(input logic j, input logic k, input logic q);
        logic nxt;
        nxt = q;
        case (jk_decode(j, k))
            JK_HOLD:   nxt = q;
            JK_CLEAR:  nxt = 1'b0;
            JK_SET:    nxt = 1'b1;
            JK_TOGGLE: nxt = ~q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jkff_jk_bit.sv
// Single JK storage cell with asynchronous active-low reset to a fixed value.
module jkff_jk_bit
    import jkff_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= jk_next(j, k, q);
        end
    end

endmodule

// File: rtl/jkff.sv
// Bank of independent JK flip-flops; q_ is always the live complement of q.
module jkff
    import jkff_pkg::*;
#(
    parameter int unsigned         WIDTH       = 1,
    parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_
);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        jkff_jk_bit #(
            .RESET_VALUE (RESET_VALUE[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .j   (j[i]),
            .k   (k[i]),
            .q   (q[i])
        );
    end

    // Derived, not stored, so q and q_ can never agree.
    assign q_ = ~q;

endmodule

// File: tb/tb_jkff.sv
// Directed table-driven bench for the JK flip-flop bank (1-bit and 4-bit builds).
module tb_jkff;

    typedef struct {
        logic       rst;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] q;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst1, rst4;
    logic [0:0] j1, k1, q1, q1_b;
    logic [3:0] j4, k4, q4, q4_b;

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    jkff u1 (
        .j   (j1),
        .k   (k1),
        .clk (clk),
        .rst (rst1),
        .q   (q1),
        .q_  (q1_b)
    );

    jkff #(
        .WIDTH       (4),
        .RESET_VALUE (4'b1010)
    ) u4 (
        .j   (j4),
        .k   (k4),
        .clk (clk),
        .rst (rst4),
        .q   (q4),
        .q_  (q4_b)
    );

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic [3:0] exp);
        chk({nm, ".q"},  {3'b000, q1},   exp & 4'b0001);
        chk({nm, ".q_"}, {3'b000, q1_b}, ~exp & 4'b0001);
    endtask

    task automatic chk4(input string nm, input logic [3:0] exp);
        chk({nm, ".q"},  q4,   exp);
        chk({nm, ".q_"}, q4_b, ~exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl1[$];
        vec_t tbl4[$];

        // 1-bit: reset hold, set, clear via K, toggle, hold
        for (int n = 0; n < 3; n++) tbl1.push_back('{1'b0, 4'h1, 4'h0, 4'h0});
        for (int n = 0; n < 5; n++) tbl1.push_back('{1'b1, 4'h1, 4'h0, 4'h1});
        tbl1.push_back('{1'b1, 4'h0, 4'h1, 4'h0});
        for (int n = 0; n < 5; n++) tbl1.push_back('{1'b1, 4'h1, 4'h1, 4'(n % 2 == 0)});
        for (int n = 0; n < 5; n++) tbl1.push_back('{1'b1, 4'h0, 4'h0, 4'h1});

        // 4-bit: reset hold, then mixed per-bit ops (b3 toggle, b2 set, b1 clear, b0 hold)
        for (int n = 0; n < 2; n++) tbl4.push_back('{1'b0, 4'hF, 4'h0, 4'b1010});
        tbl4.push_back('{1'b1, 4'b1100, 4'b1010, 4'b0100});
        tbl4.push_back('{1'b1, 4'b1100, 4'b1010, 4'b1100});
        tbl4.push_back('{1'b1, 4'b0001, 4'b0000, 4'b1101});
        tbl4.push_back('{1'b1, 4'b0000, 4'b1111, 4'b0000});
        tbl4.push_back('{1'b1, 4'b1111, 4'b1111, 4'b1111});
        tbl4.push_back('{1'b1, 4'b0000, 4'b0000, 4'b1111});

        rst1 = 1'b1; j1 = 1'b1; k1 = 1'b0;
        rst4 = 1'b1; j4 = 4'hF; k4 = 4'h0;
        #2;
        rst1 = 1'b0;
        rst4 = 1'b0;
        #1;
        chk1("async_reset_w1", 4'h0);
        chk4("async_reset_w4", 4'b1010);

        for (int i = 0; i < tbl1.size(); i++) begin
            @(negedge clk);
            rst1 = tbl1[i].rst; j1 = tbl1[i].j[0]; k1 = tbl1[i].k[0];
            @(posedge clk);
            #1;
            chk1($sformatf("w1_vec%0d", i), tbl1[i].q);
        end

        // Mid-cycle async reset on the 1-bit build, starting from q=1 with j=k=1.
        @(negedge clk); j1 = 1'b0; k1 = 1'b1;
        @(posedge clk); #1; chk1("w1_pre_clear", 4'h0);
        @(negedge clk); j1 = 1'b1; k1 = 1'b1;
        @(posedge clk); #1; chk1("w1_pre_toggle", 4'h1);
        #4; rst1 = 1'b0;
        #1; chk1("w1_midcycle_reset", 4'h0);
        @(posedge clk); #1; chk1("w1_reset_across_edge", 4'h0);
        @(negedge clk); rst1 = 1'b1;
        #1; chk1("w1_release_no_edge", 4'h0);
        @(posedge clk); #1; chk1("w1_first_edge_toggle", 4'h1);
        @(posedge clk); #1; chk1("w1_div2", 4'h0);

        for (int i = 0; i < tbl4.size(); i++) begin
            @(negedge clk);
            rst4 = tbl4[i].rst; j4 = tbl4[i].j; k4 = tbl4[i].k;
            @(posedge clk);
            #1;
            chk4($sformatf("w4_vec%0d", i), tbl4[i].q);
        end

        // Same async sequence on the 4-bit build with its non-zero reset value.
        @(negedge clk); rst4 = 1'b0;
        #1; chk4("w4_reset_again", 4'b1010);
        @(negedge clk); rst4 = 1'b1; j4 = 4'hF; k4 = 4'hF;
        @(posedge clk); #1; chk4("w4_first_edge_toggle", 4'b0101);
        #4; rst4 = 1'b0;
        #1; chk4("w4_midcycle_reset", 4'b1010);
        @(negedge clk); rst4 = 1'b1;
        @(posedge clk); #1; chk4("w4_release_toggle", 4'b0101);
        @(posedge clk); #1; chk4("w4_div2", 4'b1010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
